// File: rtl/wb_qei_if.sv
// Chip-select register port between the local bridge and one QEI macro.
// Latency: n/a (signal bundle only).
// Backpressure: none; the slave acks each access once, one cycle after cs is seen.
// Ports: wbs_cs_i/wbs_we_i/wbs_adr_i/wbs_dat_i driven by the master,
//        wbs_ack_o/wbs_dat_o driven by the slave.
interface wb_qei_if;
    logic        wbs_cs_i;
    logic        wbs_we_i;
    logic [11:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cs_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cs_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_qei.sv
// Quadrature encoder interface: x4 decode of ChA/ChB into a wrapping position and a velocity sample.
// Latency: pin edge to POS is 3 cycles (3+FILT_LEN with QEI_FILTER_EN); register ack 1 cycle after cs.
// Backpressure: none; one ack per cs assertion, cs must drop for a cycle before the next access.
// Ports: wb_clk_i/wb_rst_i (async active-high), wbs (wb_qei_if.slave register port),
//        qei_cha_i/qei_chb_i (asynchronous encoder pins), irq_o (level interrupt).
// Optional build macro: QEI_FILTER_EN adds a per-channel glitch filter of FILT_LEN samples.
module wb_qei #(
    parameter int CNT_W    = 32,
    parameter int VEL_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_i,
    wb_qei_if.slave  wbs,
    input  logic     qei_cha_i,
    input  logic     qei_chb_i,
    output logic     irq_o
);

    if (CNT_W < 8 || CNT_W > 32 || VEL_W < 2 || VEL_W > 32 || FILT_LEN < 1) begin : g_bad_param
        $error("wb_qei: parameter out of range");
    end

    localparam logic [CNT_W-1:0]       POS_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [VEL_W:0]  VEL_MAX = {2'b00, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W:0]  VEL_MIN = {2'b11, {(VEL_W-2){1'b0}}, 1'b1};

    // ---------------- registers ----------------
    logic [5:0]              ctrl;
    logic [CNT_W-1:0]        pos;
    logic [CNT_W-1:0]        max_q;
    logic [31:0]             vper;
    logic signed [VEL_W-1:0] vel;
    logic signed [VEL_W-1:0] vel_acc;
    logic [31:0]             vel_tmr;
    logic                    st_dir, st_ovf, st_unf, st_vrdy, st_err;

    wire ctl_en   = ctrl[0];
    wire ctl_swap = ctrl[1];

    // ---------------- bus access ----------------
    logic        busy;
    logic        acc_go, wr_go;
    logic [2:0]  reg_sel;
    logic [31:0] rd_mux;
    logic        unused_adr;

    assign reg_sel    = wbs.wbs_adr_i[4:2];
    assign unused_adr = ^{wbs.wbs_adr_i[11:5], wbs.wbs_adr_i[1:0]};
    // busy tracks cs from the previous cycle, so only the first cs-high cycle is accepted
    assign acc_go     = wbs.wbs_cs_i & ~busy;
    assign wr_go      = acc_go & wbs.wbs_we_i;

    wire wr_ctrl = wr_go && (reg_sel == 3'd0);
    wire wr_pos  = wr_go && (reg_sel == 3'd1);
    wire wr_max  = wr_go && (reg_sel == 3'd2);
    wire wr_vper = wr_go && (reg_sel == 3'd3);
    wire wr_stat = wr_go && (reg_sel == 3'd5);

    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            3'd0: rd_mux = {26'h0, ctrl};
            3'd1: rd_mux = 32'(pos);
            3'd2: rd_mux = 32'(max_q);
            3'd3: rd_mux = vper;
            3'd4: rd_mux = 32'(vel);
            3'd5: rd_mux = {27'h0, st_err, st_vrdy, st_unf, st_ovf, st_dir};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busy          <= 1'b0;
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= 32'h0;
        end else begin
            busy          <= wbs.wbs_cs_i;
            wbs.wbs_ack_o <= acc_go;
            wbs.wbs_dat_o <= (acc_go && !wbs.wbs_we_i) ? rd_mux : 32'h0;
        end
    end

    // ---------------- input path ----------------
    // bit 1 = A, bit 0 = B throughout
    logic [1:0] sync1, sync2, clean_ab, cur_ab, prev_ab;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {qei_cha_i, qei_chb_i};
            sync2 <= sync1;
        end
    end

`ifdef QEI_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);
    logic [FCW-1:0] filt_cnt [2];
    logic [1:0]     filt_q;

    // Output follows the input only after FILT_LEN consecutive samples at the new level;
    // any sample back at the old level restarts the count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            filt_q <= 2'b00;
            for (int i = 0; i < 2; i++) filt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FCW'(FILT_LEN - 1)) begin
                    filt_q[i]   <= sync2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign clean_ab = filt_q;
`else
    assign clean_ab = sync2;
`endif

    // Toggling swap while A != B looks like a double transition and flags err.
    assign cur_ab = ctl_swap ? {clean_ab[0], clean_ab[1]} : clean_ab;

    // ---------------- decode ----------------
    logic dec_up, dec_dn, dec_bad;

    always_comb begin
        dec_up  = 1'b0;
        dec_dn  = 1'b0;
        dec_bad = 1'b0;
        case ({prev_ab, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: dec_up  = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: dec_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: dec_bad = 1'b1;
            default: ;
        endcase
    end

    wire step_up  = ctl_en & dec_up;
    wire step_dn  = ctl_en & dec_dn;
    wire err_set  = ctl_en & dec_bad;
    // a POS write in the same cycle drops the step entirely, flags included
    wire pos_up   = step_up & ~wr_pos;
    wire pos_dn   = step_dn & ~wr_pos;
    wire ovf_set  = pos_up & (pos >= max_q);
    wire unf_set  = pos_dn & (pos == '0);

    // ---------------- velocity ----------------
    logic signed [VEL_W:0]   step_w, acc_sum;
    logic signed [VEL_W-1:0] acc_sat;

    wire vel_run  = ctl_en & (vper != 32'h0);
    wire vel_tc   = vel_run & (vel_tmr == vper - 32'd1);
    wire vrdy_set = vel_tc & ~wr_vper;

    always_comb begin
        step_w = '0;
        if (step_up) step_w = {{VEL_W{1'b0}}, 1'b1};
        if (step_dn) step_w = '1;
        acc_sum = {vel_acc[VEL_W-1], vel_acc} + step_w;
        acc_sat = acc_sum[VEL_W-1:0];
        if (acc_sum > VEL_MAX) acc_sat = VEL_MAX[VEL_W-1:0];
        if (acc_sum < VEL_MIN) acc_sat = VEL_MIN[VEL_W-1:0];
    end

    // ---------------- state ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl    <= 6'h0;
            pos     <= '0;
            max_q   <= '0;
            vper    <= 32'h0;
            vel     <= '0;
            vel_acc <= '0;
            vel_tmr <= 32'h0;
            prev_ab <= 2'b00;
            st_dir  <= 1'b0;
            st_ovf  <= 1'b0;
            st_unf  <= 1'b0;
            st_vrdy <= 1'b0;
            st_err  <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            prev_ab <= cur_ab;

            if (wr_ctrl) ctrl  <= wbs.wbs_dat_i[5:0];
            if (wr_max)  max_q <= wbs.wbs_dat_i[CNT_W-1:0];

            if (wr_pos)           pos <= wbs.wbs_dat_i[CNT_W-1:0];
            else if (ovf_set)     pos <= '0;
            else if (pos_up)      pos <= pos + POS_ONE;
            else if (unf_set)     pos <= max_q;
            else if (pos_dn)      pos <= pos - POS_ONE;

            if (pos_up)      st_dir <= 1'b1;
            else if (pos_dn) st_dir <= 1'b0;

            // sticky flags: a set in the same cycle as a W1C write survives
            st_ovf  <= ovf_set  | (st_ovf  & ~(wr_stat & wbs.wbs_dat_i[1]));
            st_unf  <= unf_set  | (st_unf  & ~(wr_stat & wbs.wbs_dat_i[2]));
            st_vrdy <= vrdy_set | (st_vrdy & ~(wr_stat & wbs.wbs_dat_i[3]));
            st_err  <= err_set  | (st_err  & ~(wr_stat & wbs.wbs_dat_i[4]));

            if (wr_vper) begin
                vper    <= wbs.wbs_dat_i;
                vel_tmr <= 32'h0;
                vel_acc <= '0;
            end else if (vel_run) begin
                if (vel_tc) begin
                    vel     <= vel_acc;
                    vel_acc <= step_w[VEL_W-1:0];
                    vel_tmr <= 32'h0;
                end else begin
                    vel_acc <= acc_sat;
                    vel_tmr <= vel_tmr + 32'd1;
                end
            end

            irq_o <= |({st_err, st_vrdy, st_unf, st_ovf} & ctrl[5:2]);
        end
    end

endmodule

// File: tb/tb_wb_qei.sv
module tb_wb_qei;

    logic clk = 1'b0;
    logic rst;
    logic cha, chb;
    logic irq;

    always #5 clk = ~clk;

    wb_qei_if bus ();

    wb_qei #(.CNT_W(32), .VEL_W(16), .FILT_LEN(3)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus),
        .qei_cha_i(cha),
        .qei_chb_i(chb),
        .irq_o    (irq)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ack_cnt = 0;
    logic [31:0] exp_q [$];
    string       name_q[$];
    logic        irq_at_ack;
    logic [1:0]  ab = 2'b00;
    logic        last_dir = 1'b0;

    // ---------------- scoreboard monitor ----------------
    logic [31:0] mon_exp;
    string       mon_name;
    logic        ack_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.wbs_ack_o) begin
            ack_cnt++;
            n_cmp++;
            if (ack_prev) begin
                n_bad++;
                $display("FAIL ack_width: ack high two cycles running, required one-cycle pulse");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack: dat=%h with no access outstanding", bus.wbs_dat_o);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (bus.wbs_dat_o !== mon_exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h required %h", mon_name, bus.wbs_dat_o, mon_exp);
                end
            end
        end
        ack_prev = bus.wbs_ack_o;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    // ---------------- bus master ----------------
    task automatic xfer(input logic we, input logic [11:0] adr, input logic [31:0] wd,
                        input logic [31:0] req, input string nm);
        logic got;
        exp_q.push_back(we ? 32'h0 : req);
        name_q.push_back(nm);
        @(negedge clk);
        bus.wbs_cs_i  = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                got        = 1'b1;
                irq_at_ack = irq;
            end
        end
        bus.wbs_cs_i = 1'b0;
        bus.wbs_we_i = 1'b0;
        if (!got) begin
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no ack within 8 cycles, required ack", nm);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] adr, input logic [31:0] wd);
        xfer(1'b1, adr, wd, 32'h0, $sformatf("wr_%h", adr));
    endtask

    task automatic rd(input logic [11:0] adr, input logic [31:0] req, input string nm);
        xfer(1'b0, adr, 32'h0, req, nm);
    endtask

    // ---------------- encoder stimulus ----------------
    function automatic logic [1:0] nxt(input logic [1:0] s, input logic fwd);
        logic [1:0] f;
        case (s)
            2'b00: f = 2'b01;
            2'b01: f = 2'b11;
            2'b11: f = 2'b10;
            default: f = 2'b00;
        endcase
        if (!fwd) begin
            case (s)
                2'b00: f = 2'b10;
                2'b10: f = 2'b11;
                2'b11: f = 2'b01;
                default: f = 2'b00;
            endcase
        end
        return f;
    endfunction

    task automatic edges(input int n, input logic fwd, input int gap);
        for (int i = 0; i < n; i++) begin
            ab  = nxt(ab, fwd);
            cha = ab[1];
            chb = ab[0];
            last_dir = fwd;
            repeat (gap) @(negedge clk);
        end
    endtask

    localparam logic [11:0] A_CTRL = 12'h00, A_POS = 12'h04, A_MAX = 12'h08,
                            A_VPER = 12'h0C, A_VEL = 12'h10, A_STAT = 12'h14, A_NONE = 12'h1C;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        rst = 1'b1;
        cha = 1'b0;
        chb = 1'b0;
        bus.wbs_cs_i  = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 12'h0;
        bus.wbs_dat_i = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check("reset_dat", bus.wbs_dat_o, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset values and an unmapped read
        rd(A_CTRL, 32'h0, "rst_ctrl");
        rd(A_POS,  32'h0, "rst_pos");
        rd(A_MAX,  32'h0, "rst_max");
        rd(A_VPER, 32'h0, "rst_vper");
        rd(A_VEL,  32'h0, "rst_vel");
        rd(A_STAT, 32'h0, "rst_stat");
        acks0 = ack_cnt;
        rd(A_NONE, 32'h0, "unmapped_rd");
        check("unmapped_ack_count", ack_cnt - acks0, 32'd1);
        check("rst_irq_after", {31'h0, irq}, 32'h0);

        // 2: forward counting and overflow
        wr(A_MAX, 32'd99);
        wr(A_CTRL, 32'h01);
        edges(16, 1'b1, 4);
        repeat (6) @(negedge clk);
        rd(A_POS,  32'd16, "fwd16_pos");
        rd(A_STAT, 32'h01, "fwd16_stat");
        wr(A_POS, 32'd98);
        edges(3, 1'b1, 4);
        repeat (6) @(negedge clk);
        rd(A_POS,  32'd1,  "ovf_pos");
        rd(A_STAT, 32'h03, "ovf_stat");
        wr(A_CTRL, 32'h05);
        check("ovf_irq", {31'h0, irq}, 32'h1);

        // 3: underflow and W1C clear
        wr(A_CTRL, 32'h09);
        check("unf_irq_idle", {31'h0, irq}, 32'h0);
        wr(A_POS, 32'd0);
        edges(2, 1'b0, 4);
        repeat (6) @(negedge clk);
        rd(A_POS,  32'd98, "unf_pos");
        rd(A_STAT, 32'h06, "unf_stat");
        check("unf_irq", {31'h0, irq}, 32'h1);
        wr(A_STAT, 32'h04);
        check("w1c_irq_in_ack", {31'h0, irq_at_ack}, 32'h1);
        check("w1c_irq_after", {31'h0, irq}, 32'h0);
        rd(A_STAT, 32'h02, "w1c_stat");

        // 4: velocity sampling, forward then reverse
        wr(A_CTRL, 32'h01);
        wr(A_STAT, 32'h1E);
        wr(A_POS, 32'd0);
        wr(A_VPER, 32'd100);
        edges(10, 1'b1, 8);
        repeat (45) @(negedge clk);
        rd(A_VEL,  32'd10,  "vel_fwd");
        rd(A_STAT, 32'h09,  "vel_fwd_stat");
        rd(A_POS,  32'd10,  "vel_fwd_pos");
        wr(A_VPER, 32'd100);
        wr(A_STAT, 32'h08);
        edges(10, 1'b0, 8);
        repeat (45) @(negedge clk);
        rd(A_VEL,  32'hFFFF_FFF6, "vel_rev");
        rd(A_STAT, 32'h08,        "vel_rev_stat");
        wr(A_VPER, 32'd0);
        wr(A_STAT, 32'h1E);

        // 5: illegal double transition, then swapped direction
        while (ab != 2'b00) edges(1, 1'b1, 4);
        wr(A_POS, 32'd50);
        ab = 2'b11; cha = 1'b1; chb = 1'b1;
        repeat (6) @(negedge clk);
        rd(A_POS,  32'd50, "err_pos");
        rd(A_STAT, {27'h0, 4'h8, last_dir}, "err_stat");
        ab = 2'b00; cha = 1'b0; chb = 1'b0;
        repeat (6) @(negedge clk);
        wr(A_STAT, 32'h10);
        wr(A_CTRL, 32'h03);
        edges(4, 1'b1, 4);
        repeat (6) @(negedge clk);
        rd(A_POS,  32'd46, "swap_pos");
        rd(A_STAT, 32'h00, "swap_stat");
        wr(A_CTRL, 32'h01);

        // 6: cs held for 5 cycles yields a single ack
        acks0 = ack_cnt;
        exp_q.push_back(32'h0);
        name_q.push_back("hold_cs");
        @(negedge clk);
        bus.wbs_cs_i  = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = A_NONE;
        repeat (5) @(negedge clk);
        bus.wbs_cs_i = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_cs_ack_count", ack_cnt - acks0, 32'd1);

`ifdef QEI_FILTER_EN
        wr(A_POS, 32'd10);
        cha = 1'b1;
        repeat (2) @(negedge clk);
        cha = 1'b0;
        repeat (12) @(negedge clk);
        rd(A_POS, 32'd10, "filt_glitch_pos");
        edges(1, 1'b1, 12);
        rd(A_POS, 32'd11, "filt_edge_pos");
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
